// File: rtl/uart_pkg.sv
// uart_pkg: UART register addresses, CON bit positions and the FSM state type.
// The TX and RX state machines both use this state type.
package uart_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_TX_IE    = 0;
  localparam int CON_RX_IE    = 1;
  localparam int CON_TX_DONE  = 2;
  localparam int CON_RX_VALID = 3;
  localparam int CON_TX_BUSY  = 4;
  localparam int CON_OVERRUN  = 5;
  localparam int CON_PAR_ERR  = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: input synchroniser, mid-bit sampling RX FSM and bit divider.
// Define UART_PARITY_EN to expect an even parity bit before the stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 5208
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_parErr
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2 - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_valid;
  logic          r_parErr;
`ifdef UART_PARITY_EN
  logic          r_parBit;
`endif

  assign o_byte   = r_byte;
  assign o_valid  = r_valid;
  assign o_parErr = r_parErr;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // START waits half a bit to re-check the line, so later samples land mid-bit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_byte   <= '0;
      r_valid  <= 1'b0;
      r_parErr <= 1'b0;
`ifdef UART_PARITY_EN
      r_parBit <= 1'b0;
`endif
    end else begin
      r_valid  <= 1'b0;
      r_parErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == DIV_HALF) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_state <= r_sync2 ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt    <= '0;
            r_parBit <= r_sync2;
            r_state  <= STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (r_sync2) begin
              r_byte  <= r_shift;
              r_valid <= 1'b1;
`ifdef UART_PARITY_EN
              r_parErr <= (r_parBit != ^r_shift);
`endif
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_periph.sv
// uart_periph: memory-mapped UART with TXD/RXD/CON registers, TX FSM and level IRQ.
// Define UART_PARITY_EN to add an even parity bit in both directions.
module uart_periph
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tx,
  input  logic        rx
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  uart_state_t   r_txState;
  logic [CW-1:0] r_txCnt;
  logic [2:0]    r_txBit;
  logic [7:0]    r_txShift;
  logic [7:0]    r_txByte;
  logic          r_tx;
  logic          r_txIe;
  logic          r_rxIe;
  logic          r_txDone;
  logic          r_rxValid;
  logic          r_overrun;
  logic          r_parErr;
  logic [7:0]    r_rxByte;

  logic          w_txBusy;
  logic          w_txdWrite;
  logic          w_conWrite;
  logic          w_rxdRead;
  logic          w_conRead;
  logic          w_txFinish;
  logic [7:0]    w_rxByte;
  logic          w_rxValid;
  logic          w_rxParErr;
  logic [31:0]   w_con;
  logic          w_unused;

  assign w_txBusy   = (r_txState != IDLE);
  assign w_txdWrite = wr && (addr == UART_TXD_ADDR) && !w_txBusy;
  assign w_conWrite = wr && (addr == UART_CON_ADDR);
  assign w_rxdRead  = rd && (addr == UART_RXD_ADDR);
  assign w_conRead  = rd && (addr == UART_CON_ADDR);
  assign w_txFinish = (r_txState == STOP) && (r_txCnt == DIV_LAST);
  assign w_unused   = ^wdata[31:8];

  assign tx  = r_tx;
  assign irq = (r_txIe & r_txDone) | (r_rxIe & r_rxValid);

  uart_rx_core #(
    .CLK_DIV (CLK_DIV)
  ) u_rxCore (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_rx     (rx),
    .o_byte   (w_rxByte),
    .o_valid  (w_rxValid),
    .o_parErr (w_rxParErr)
  );

  // Each non-idle state lasts CLK_DIV cycles; tx is registered so it never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txState <= IDLE;
      r_txCnt   <= '0;
      r_txBit   <= '0;
      r_txShift <= '0;
      r_txByte  <= '0;
      r_tx      <= 1'b1;
    end else if (r_txState == IDLE) begin
      if (w_txdWrite) begin
        r_txState <= START;
        r_txCnt   <= '0;
        r_txShift <= wdata[7:0];
        r_txByte  <= wdata[7:0];
        r_tx      <= 1'b0;
      end
    end else if (r_txCnt != DIV_LAST) begin
      r_txCnt <= r_txCnt + CW'(1);
    end else begin
      r_txCnt <= '0;
      case (r_txState)
        START: begin
          r_txState <= DATA;
          r_txBit   <= '0;
          r_tx      <= r_txShift[0];
        end
        DATA: begin
          if (r_txBit == 3'd7) begin
`ifdef UART_PARITY_EN
            r_txState <= PARITY;
            r_tx      <= ^r_txByte;
`else
            r_txState <= STOP;
            r_tx      <= 1'b1;
`endif
          end else begin
            r_txBit   <= r_txBit + 3'd1;
            r_txShift <= r_txShift >> 1;
            r_tx      <= r_txShift[1];
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          r_txState <= STOP;
          r_tx      <= 1'b1;
        end
`endif
        default: begin
          r_txState <= IDLE;
          r_tx      <= 1'b1;
        end
      endcase
    end
  end

  // Clear-on-read is applied first so that a same-cycle set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txIe    <= 1'b0;
      r_rxIe    <= 1'b0;
      r_txDone  <= 1'b0;
      r_rxValid <= 1'b0;
      r_overrun <= 1'b0;
      r_parErr  <= 1'b0;
      r_rxByte  <= '0;
    end else begin
      if (w_conWrite) begin
        r_txIe <= wdata[0];
        r_rxIe <= wdata[1];
      end
      if (w_conRead) begin
        r_txDone  <= 1'b0;
        r_overrun <= 1'b0;
        r_parErr  <= 1'b0;
      end
      if (w_rxdRead) begin
        r_rxValid <= 1'b0;
      end
      if (w_txFinish) begin
        r_txDone <= 1'b1;
      end
      if (w_rxValid) begin
        r_rxByte  <= w_rxByte;
        r_rxValid <= 1'b1;
        if (r_rxValid && !w_rxdRead) begin
          r_overrun <= 1'b1;
        end
      end
      if (w_rxParErr) begin
        r_parErr <= 1'b1;
      end
    end
  end

  always_comb begin
    w_con                 = '0;
    w_con[CON_TX_IE]      = r_txIe;
    w_con[CON_RX_IE]      = r_rxIe;
    w_con[CON_TX_DONE]    = r_txDone;
    w_con[CON_RX_VALID]   = r_rxValid;
    w_con[CON_TX_BUSY]    = w_txBusy;
    w_con[CON_OVERRUN]    = r_overrun;
    w_con[CON_PAR_ERR]    = r_parErr;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        UART_TXD_ADDR: rdata = {24'd0, r_txByte};
        UART_RXD_ADDR: rdata = {24'd0, r_rxByte};
        UART_CON_ADDR: rdata = w_con;
        default:       rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: randomized self-checking bench for uart_periph at CLK_DIV=16.
// Expected frames and register values come from a bit-level frame model.
module tb_uart_periph;

  localparam int D = 16;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        tx;
  logic        rx;

  int passCount = 0;
  int checkCount = 0;

  uart_periph #(
    .CLK_DIV (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq),
    .tx    (tx),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  // Line level of bit k in a frame: start, 8 data LSB first, optional even parity, stop.
  function automatic logic frameBit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == NBITS - 1) return 1'b1;
    return ^b;
  endfunction

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd = 1'b1;
    addr = a;
    #1 d = rdata;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic sendRxFrame(input logic [7:0] b, input logic stopBit, input logic badPar);
    logic v;
    for (int k = 0; k < NBITS; k++) begin
      v = frameBit(b, k);
      if (k == NBITS - 1) v = stopBit;
      else if (k == 9) v = v ^ badPar;
      @(negedge clk);
      rx = v;
      repeat (D - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++;
    if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", tx);
    else passCount++;
    checkCount++;
    if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    else passCount++;
    checkCount++;
    if (rdata !== 32'd0) $display("[TB] FAIL reset_rdata: got %h expected 0", rdata);
    else passCount++;
    @(negedge clk);
    reset = 1'b1;
    busRead(A_CON, d);
    checkCount++;
    if (d !== 32'd0) $display("[TB] FAIL reset_con: got %h expected 0", d);
    else passCount++;
    busRead(A_TXD, d);
    checkCount++;
    if (d !== 32'd0) $display("[TB] FAIL reset_txd: got %h expected 0", d);
    else passCount++;
    busRead(A_RXD, d);
    checkCount++;
    if (d !== 32'd0) $display("[TB] FAIL reset_rxd: got %h expected 0", d);
    else passCount++;
  endtask

  task automatic test_decode();
    logic [31:0] d;
    busWrite(A_CON, 32'hFFFF_FFFF);
    busRead(A_CON, d);
    checkCount++;
    if (d !== 32'h3) $display("[TB] FAIL con_write_mask: got %h expected 3", d);
    else passCount++;
    busWrite(A_CON, 32'h0);
    busWrite(32'hC000_0020, 32'h3);
    busWrite(32'h4000_0010, 32'h3);
    busRead(A_CON, d);
    checkCount++;
    if (d !== 32'h0) $display("[TB] FAIL decode_alias_write: got %h expected 0", d);
    else passCount++;
    busRead(32'h4000_0024, d);
    checkCount++;
    if (d !== 32'h0) $display("[TB] FAIL decode_unmapped_read: got %h expected 0", d);
    else passCount++;
  endtask

  // dropAt >= 0 issues a second TXD write of b2 in that frame cycle; it must be ignored.
  task automatic test_tx(input logic [7:0] b, input logic ie, input int dropAt, input logic [7:0] b2);
    logic [31:0] d;
    logic expTx;
    logic expIrq;
    busWrite(A_CON, {31'd0, ie});
    busRead(A_CON, d);
    @(negedge clk);
    wr = 1'b1;
    addr = A_TXD;
    wdata = {24'd0, b};
    for (int c = 0; c < NBITS * D + 4; c++) begin
      @(negedge clk);
      wr = 1'b0;
      rd = 1'b0;
      expTx = (c < NBITS * D) ? frameBit(b, c / D) : 1'b1;
      expIrq = (c == NBITS * D) ? ie : 1'b0;
      checkCount++;
      if (tx !== expTx) $display("[TB] FAIL tx_line c=%0d byte=%h: got %b expected %b", c, b, tx, expTx);
      else passCount++;
      checkCount++;
      if (irq !== expIrq) $display("[TB] FAIL tx_irq c=%0d: got %b expected %b", c, irq, expIrq);
      else passCount++;
      if (c == 3 * D || c == NBITS * D) begin
        rd = 1'b1;
        addr = A_CON;
        #1;
        checkCount++;
        if (c == 3 * D) begin
          if (rdata !== (32'h10 | {31'd0, ie})) $display("[TB] FAIL tx_con_busy: got %h expected %h", rdata, 32'h10 | {31'd0, ie});
          else passCount++;
        end else begin
          if (rdata !== (32'h04 | {31'd0, ie})) $display("[TB] FAIL tx_con_done: got %h expected %h", rdata, 32'h04 | {31'd0, ie});
          else passCount++;
        end
      end
      if (c == dropAt) begin
        wr = 1'b1;
        addr = A_TXD;
        wdata = {24'd0, b2};
      end
    end
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    busRead(A_TXD, d);
    checkCount++;
    if (d !== {24'd0, b}) $display("[TB] FAIL tx_txd_readback: got %h expected %h", d, {24'd0, b});
    else passCount++;
  endtask

  task automatic test_rx(input logic [7:0] b, input logic rie);
    logic [31:0] d;
    logic [31:0] en;
    en = {30'd0, rie, 1'b0};
    busWrite(A_CON, en);
    sendRxFrame(b, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checkCount++;
    if (irq !== rie) $display("[TB] FAIL rx_irq: got %b expected %b", irq, rie);
    else passCount++;
    busRead(A_CON, d);
    checkCount++;
    if (d !== (32'h08 | en)) $display("[TB] FAIL rx_con_valid: got %h expected %h", d, 32'h08 | en);
    else passCount++;
    busRead(A_RXD, d);
    checkCount++;
    if (d !== {24'd0, b}) $display("[TB] FAIL rx_rxd: got %h expected %h", d, {24'd0, b});
    else passCount++;
    busRead(A_CON, d);
    checkCount++;
    if (d !== en) $display("[TB] FAIL rx_con_cleared: got %h expected %h", d, en);
    else passCount++;
    checkCount++;
    if (irq !== 1'b0) $display("[TB] FAIL rx_irq_cleared: got %b expected 0", irq);
    else passCount++;
  endtask

  task automatic test_overrun(input logic [7:0] b1, input logic [7:0] b2, input logic [1:0] en);
    logic [31:0] d;
    busWrite(A_CON, {30'd0, en});
    sendRxFrame(b1, 1'b1, 1'b0);
    sendRxFrame(b2, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checkCount++;
    if (irq !== en[1]) $display("[TB] FAIL ovr_irq: got %b expected %b", irq, en[1]);
    else passCount++;
    busRead(A_CON, d);
    checkCount++;
    if (d !== (32'h28 | {30'd0, en})) $display("[TB] FAIL ovr_con: got %h expected %h", d, 32'h28 | {30'd0, en});
    else passCount++;
    busRead(A_CON, d);
    checkCount++;
    if (d !== (32'h08 | {30'd0, en})) $display("[TB] FAIL ovr_con_cleared: got %h expected %h", d, 32'h08 | {30'd0, en});
    else passCount++;
    busRead(A_RXD, d);
    checkCount++;
    if (d !== {24'd0, b2}) $display("[TB] FAIL ovr_rxd: got %h expected %h", d, {24'd0, b2});
    else passCount++;
    busRead(A_CON, d);
    checkCount++;
    if (d !== {30'd0, en}) $display("[TB] FAIL ovr_con_final: got %h expected %h", d, {30'd0, en});
    else passCount++;
  endtask

  task automatic test_glitch_framing(input logic [7:0] b);
    logic [31:0] d;
    busWrite(A_CON, 32'h0);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (NBITS * D + 8) @(negedge clk);
    busRead(A_CON, d);
    checkCount++;
    if (d !== 32'h0) $display("[TB] FAIL glitch_con: got %h expected 0", d);
    else passCount++;
    sendRxFrame(b, 1'b0, 1'b0);
    repeat (D) @(negedge clk);
    busRead(A_CON, d);
    checkCount++;
    if (d !== 32'h0) $display("[TB] FAIL framing_con: got %h expected 0", d);
    else passCount++;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity(input logic [7:0] b);
    logic [31:0] d;
    busWrite(A_CON, 32'h0);
    sendRxFrame(b, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    busRead(A_CON, d);
    checkCount++;
    if (d !== 32'h48) $display("[TB] FAIL parity_con: got %h expected 48", d);
    else passCount++;
    busRead(A_CON, d);
    checkCount++;
    if (d !== 32'h08) $display("[TB] FAIL parity_con_cleared: got %h expected 08", d);
    else passCount++;
    busRead(A_RXD, d);
    checkCount++;
    if (d !== {24'd0, b}) $display("[TB] FAIL parity_rxd: got %h expected %h", d, {24'd0, b});
    else passCount++;
  endtask
`endif

  task automatic test_reset_mid_tx(input logic [7:0] b);
    logic [31:0] d;
    busWrite(A_CON, 32'h3);
    busWrite(A_TXD, {24'd0, b});
    repeat (D / 2) @(negedge clk);
    checkCount++;
    if (tx !== 1'b0) $display("[TB] FAIL midtx_start_bit: got %b expected 0", tx);
    else passCount++;
    reset = 1'b0;
    #1;
    checkCount++;
    if (tx !== 1'b1) $display("[TB] FAIL midtx_reset_tx: got %b expected 1", tx);
    else passCount++;
    @(negedge clk);
    reset = 1'b1;
    busRead(A_CON, d);
    checkCount++;
    if (d !== 32'h0) $display("[TB] FAIL midtx_con: got %h expected 0", d);
    else passCount++;
    busRead(A_TXD, d);
    checkCount++;
    if (d !== 32'h0) $display("[TB] FAIL midtx_txd: got %h expected 0", d);
    else passCount++;
    repeat (2 * D) @(negedge clk);
    checkCount++;
    if (tx !== 1'b1) $display("[TB] FAIL midtx_idle_after: got %b expected 1", tx);
    else passCount++;
  endtask

  initial begin
    reset = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    rx = 1'b1;
    addr = '0;
    wdata = '0;
    test_reset();
    test_decode();
    test_tx(8'hA5, 1'b1, -1, 8'h00);
    test_tx(8'h11, 1'b0, 1, 8'h22);
    for (int i = 0; i < 3; i++) begin
      test_tx(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), NBITS * D - 1, 8'($urandom_range(0, 255)));
    end
    test_rx(8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      test_rx(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    test_overrun(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    test_glitch_framing(8'($urandom_range(0, 255)));
`ifdef UART_PARITY_EN
    test_parity(8'($urandom_range(0, 255)));
`endif
    test_reset_mid_tx(8'($urandom_range(0, 255)));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
